// File: rtl/knn_io_pipe.sv
// knn_io_pipe: retimes core inputs, synchronises the core reset and streams
// (name, value) results out of a FIFO on an AXI-Stream master with tlast framing.
module knn_io_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 1,
  parameter int IN_STAGES  = 1,
  parameter int OUT_DEPTH  = 4,
  parameter int K          = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           s_wr_en,
  input  logic                           s_done,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   s_data,
  output logic                           core_reset,
  output logic                           core_wr_en,
  output logic                           core_done,
  output logic [NUM_CH*DATA_WIDTH-1:0]   core_data,
  input  logic                           core_out_wr_en,
  input  logic [31:0]                    core_name,
  input  logic [DATA_WIDTH-1:0]          core_value,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [32+DATA_WIDTH-1:0]       m_tdata,
  output logic                           m_tlast,
  output logic                           overflow,
  output logic [$clog2(OUT_DEPTH):0]     fifo_count
);
  localparam int DW   = NUM_CH * DATA_WIDTH;
  localparam int PW   = DW + 2;
  localparam int WW   = 32 + DATA_WIDTH;
  localparam int AW   = OUT_DEPTH > 1 ? $clog2(OUT_DEPTH) : 1;
  localparam int CNTW = $clog2(OUT_DEPTH) + 1;
  localparam int CW   = K > 1 ? $clog2(K) : 1;
  logic [1:0]    rst_sync;
  logic [PW-1:0] pipe [IN_STAGES];
  logic [WW-1:0] mem [OUT_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] tcnt;
  logic          full, pop, push;
  always_ff @(posedge clk or negedge reset)
    if (!reset) rst_sync <= 2'b11;
    else rst_sync <= {rst_sync[0], 1'b0};
  assign core_reset = rst_sync[1];
  // wr_en, done and data share one delay line so they stay aligned
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < IN_STAGES; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {s_wr_en, s_done, s_data};
      for (int i = 1; i < IN_STAGES; i++) pipe[i] <= pipe[i-1];
    end
  assign {core_wr_en, core_done, core_data} = pipe[IN_STAGES-1];
  assign m_tvalid = fifo_count != '0;
  assign full     = fifo_count == CNTW'(OUT_DEPTH);
  assign pop      = m_tvalid & m_tready;
  assign push     = core_out_wr_en & (~full | pop);
  assign m_tdata  = m_tvalid ? mem[rptr] : '0;
  assign m_tlast  = m_tvalid & (tcnt == CW'(K - 1));
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {core_name, core_value};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr       <= '0;
      rptr       <= '0;
      tcnt       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wptr <= wptr == AW'(OUT_DEPTH - 1) ? '0 : wptr + 1'b1;
      if (pop) begin
        rptr <= rptr == AW'(OUT_DEPTH - 1) ? '0 : rptr + 1'b1;
        tcnt <= tcnt == CW'(K - 1) ? '0 : tcnt + 1'b1;
      end
      fifo_count <= fifo_count + CNTW'(push) - CNTW'(pop);
      if (core_out_wr_en & ~push) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_knn_io_pipe.sv
// tb_knn_io_pipe: queue-based reference model compared every cycle, plus directed
// scenarios with literal expectations for reset, latency, framing and overflow.
module tb_knn_io_pipe;
  localparam int DW = 32, NCH = 2, INS = 2, DEPTH = 4, KK = 3;
  logic clk = 0, reset = 0;
  logic s_wr_en = 0, s_done = 0;
  logic [NCH*DW-1:0] s_data = '0;
  logic core_reset, core_wr_en, core_done;
  logic [NCH*DW-1:0] core_data;
  logic core_out_wr_en = 0;
  logic [31:0] core_name = '0;
  logic [DW-1:0] core_value = '0;
  logic m_tvalid, m_tready = 0, m_tlast, overflow;
  logic [32+DW-1:0] m_tdata;
  logic [$clog2(DEPTH):0] fifo_count;
  int checks = 0, errors = 0;

  knn_io_pipe #(.DATA_WIDTH(DW), .NUM_CH(NCH), .IN_STAGES(INS), .OUT_DEPTH(DEPTH), .K(KK)) dut (
    .clk(clk), .reset(reset), .s_wr_en(s_wr_en), .s_done(s_done), .s_data(s_data),
    .core_reset(core_reset), .core_wr_en(core_wr_en), .core_done(core_done), .core_data(core_data),
    .core_out_wr_en(core_out_wr_en), .core_name(core_name), .core_value(core_value),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .overflow(overflow), .fifo_count(fifo_count));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: result queue, accepted-pop count, sticky drop flag, input history
  logic [63:0] q[$];
  logic [NCH*DW+1:0] hist[$];
  int pops = 0, since = 0;
  bit ovf = 0;
  always @(posedge clk or negedge reset) begin : model
    bit pp;
    if (!reset) begin
      q.delete(); hist.delete(); pops = 0; ovf = 0; since = 0;
    end else begin
      hist.push_front({s_wr_en, s_done, s_data});
      since++;
      pp = q.size() > 0 && m_tready;
      if (pp) begin void'(q.pop_front()); pops++; end
      if (core_out_wr_en) begin
        if (q.size() == DEPTH) ovf = 1;
        else q.push_back({core_name, core_value});
      end
    end
  end

  logic [32:0] outlog[$];
  always @(negedge clk) begin : cmp
    logic [NCH*DW+1:0] p;
    p = since >= INS ? hist[INS-1] : '0;
    chk("core_reset", core_reset, since < 2 ? 1 : 0);
    chk("core_pipe", {core_wr_en, core_done, core_data}, p);
    chk("m_tvalid", m_tvalid, q.size() > 0);
    chk("m_tdata", m_tdata, q.size() > 0 ? q[0] : 64'h0);
    chk("m_tlast", m_tlast, q.size() > 0 && (pops % KK) == KK - 1);
    chk("fifo_count", fifo_count, q.size());
    chk("overflow", overflow, ovf);
    if (reset && m_tvalid && m_tready) outlog.push_back({m_tlast, m_tdata[63:32]});
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic tickn(input int n); repeat (n) tick(); endtask
  task automatic push_burst(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      core_out_wr_en = 1; core_name = first + i; core_value = first + i + 32'h100;
      tick();
    end
    core_out_wr_en = 0;
  endtask
  task automatic pulse_reset();
    reset = 0; tick(); reset = 1; tickn(2);
  endtask

  initial begin
    // Reset hold and core_reset release timing
    tickn(5);
    @(negedge clk);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_tvalid", m_tvalid, 0);
    tick(); reset = 1;
    tick(); @(negedge clk); chk("rel_edge1", core_reset, 1);
    tick(); @(negedge clk); chk("rel_edge2", core_reset, 0);
    // Input latency
    tick(); s_wr_en = 1; s_data = 64'h0000000A_00000005;
    tick(); s_wr_en = 0; s_data = '0; s_done = 1;
    @(negedge clk); chk("lat_wr_e1", core_wr_en, 0);
    tick(); s_done = 0;
    @(negedge clk);
    chk("lat_wr_e2", core_wr_en, 1);
    chk("lat_data_e2", core_data, 64'h0000000A_00000005);
    chk("lat_done_e2", core_done, 0);
    tick(); @(negedge clk);
    chk("lat_done_e3", core_done, 1);
    chk("lat_wr_e3", core_wr_en, 0);
    // tlast framing
    outlog.delete(); m_tready = 1;
    push_burst(1, 6); tickn(4);
    chk("t3_count", outlog.size(), 6);
    for (int i = 0; i < outlog.size(); i++) begin
      chk("t3_name", outlog[i][31:0], i + 1);
      chk("t3_last", outlog[i][32], i == 2 || i == 5);
    end
    chk("t3_ovf", overflow, 0);
    // Backpressure and overflow
    m_tready = 0; outlog.delete();
    push_burst(10, 5);
    @(negedge clk);
    chk("t4_count", fifo_count, 4);
    chk("t4_ovf", overflow, 1);
    tick(); m_tready = 1; tickn(6);
    chk("t4_out_n", outlog.size(), 4);
    for (int i = 0; i < outlog.size(); i++) chk("t4_name", outlog[i][31:0], 10 + i);
    // Simultaneous push and pop on a full FIFO
    m_tready = 0; pulse_reset();
    push_burst(16, 4);
    @(negedge clk); chk("t5_full", fifo_count, 4);
    tick(); outlog.delete();
    m_tready = 1; core_out_wr_en = 1; core_name = 20; core_value = 32'h120;
    tick(); core_out_wr_en = 0; m_tready = 0;
    @(negedge clk);
    chk("t5_ovf", overflow, 0);
    chk("t5_count", fifo_count, 4);
    tick(); m_tready = 1; tickn(6);
    chk("t5_out_n", outlog.size(), 5);
    for (int i = 0; i < outlog.size(); i++) chk("t5_name", outlog[i][31:0], 16 + i);
    // Mid-stream reset
    m_tready = 0;
    push_burst(30, 3);
    @(negedge clk); chk("t6_pre", fifo_count, 3);
    tick(); reset = 0; #1;
    chk("t6_tvalid", m_tvalid, 0);
    chk("t6_count", fifo_count, 0);
    chk("t6_core_reset", core_reset, 1);
    tick(); reset = 1; tickn(2);
    outlog.delete(); m_tready = 1;
    push_burst(40, 3); tickn(4);
    chk("t6_out_n", outlog.size(), 3);
    for (int i = 0; i < outlog.size(); i++) begin
      chk("t6_name", outlog[i][31:0], 40 + i);
      chk("t6_last", outlog[i][32], i == 2);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/knn_io_pipe.md
Name: knn_io_pipe

Overview:
- Parametrised I/O pipeline wrapper placed between the AXI-Stream DMA interface and the KNN core.
- Input path: retimes the core control and data inputs through a configurable number of register stages. It also generates the core's active-high reset.
- Output path: buffers each (name, value) result in a FIFO and drives it out on an AXI-Stream master with full tvalid/tready backpressure. tlast is asserted on every K-th result.
- Sticky overflow flag marks lost results.

Parameters:
- DATA_WIDTH, 32, width of one channel sample and of the result value.
- NUM_CH, 1, number of input channels packed on s_data.
- IN_STAGES, 1, input register depth; legal range 1..4.
- OUT_DEPTH, 4, result FIFO depth; power of 2, must be >= K.
- K, 1, results per query; sets the tlast period.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- s_wr_en  in  1  input sample valid.
- s_done  in  1  end-of-dataset strobe.
- s_data  in  NUM_CH*DATA_WIDTH  input samples.
- core_reset  out  1  active-high reset to the core.
- core_wr_en  out  1  retimed s_wr_en.
- core_done  out  1  retimed s_done.
- core_data  out  NUM_CH*DATA_WIDTH  retimed s_data.
- core_out_wr_en  in  1  core result strobe.
- core_name  in  32  result identifier.
- core_value  in  DATA_WIDTH  result distance.
- m_tvalid  out  1  output word valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  32+DATA_WIDTH  output word, {name, value}.
- m_tlast  out  1  last result of a query.
- overflow  out  1  sticky; a result was dropped.
- fifo_count  out  $clog2(OUT_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous) forces these values:
  - core_reset=1.
  - All pipeline bits =0, so core_wr_en, core_done and core_data are 0.
  - FIFO empty: fifo_count=0, m_tvalid=0, m_tdata=0, m_tlast=0.
  - overflow=0; tlast counter=0.
- core_reset release:
  - Asserts asynchronously when reset goes low.
  - Deasserts through a 2-flop synchroniser: low on the 2nd rising edge after reset returns high.
- Input pipe:
  - wr_en, done and data are delayed identically by exactly IN_STAGES cycles, so alignment is preserved.
  - No gating: every input cycle reaches the core, including back-to-back writes.
  - Inputs presented while core_reset=1 still propagate through the pipe; the core ignores them.
- FIFO push:
  - Push occurs on a cycle with core_out_wr_en=1.
  - It writes {core_name, core_value} at the write pointer.
- FIFO pop:
  - Pop occurs on a cycle with m_tvalid=1 and m_tready=1.
- Outputs:
  - m_tvalid = FIFO not empty.
  - m_tdata = head entry.
  - Registered: a push into an empty FIFO gives m_tvalid=1 on the next cycle.
  - m_tdata and m_tlast hold stable while m_tvalid=1 and m_tready=0.
- Full FIFO:
  - Push with no simultaneous pop: the word is dropped, overflow is set (sticky until reset) and the pointers are unchanged.
  - Push together with a pop: both are accepted and fifo_count stays at OUT_DEPTH.
- Empty FIFO with a simultaneous push: no pop possible; count goes 0->1.
- Pointers: wrap modulo OUT_DEPTH; fifo_count = pushes - pops (accepted only).
- tlast counter:
  - Range 0..K-1; increments on each pop and wraps to 0 after K-1.
  - m_tlast = m_tvalid & (counter==K-1).
  - K=1: every word has tlast=1.
  - Dropped words do not advance the counter.
- Reset mid-operation:
  - Contents are discarded immediately and pointers and counter clear.
  - Results arriving while core_reset=1 are still accepted, if any.

Test Plan:
1. Reset check: hold reset=0 for 5 cycles, then release.
   - During reset: all outputs at their reset values, core_reset=1.
   - core_reset falls on the 2nd edge after release.
2. Input latency: IN_STAGES=2, NUM_CH=2, drive s_wr_en=1 with s_data=0x0000000A_00000005 for one cycle, and s_done=1 on the following cycle.
   - core_wr_en and core_data appear exactly 2 cycles later.
   - core_done appears on the next cycle after that.
3. tlast framing: K=3, m_tready=1, push names 1,2,3,4,5,6 on consecutive cycles.
   - Six words out in order.
   - m_tlast=1 only on names 3 and 6; overflow=0.
4. Backpressure and overflow: OUT_DEPTH=4, m_tready=0, push 5 results (names 10..14).
   - fifo_count=4, overflow=1.
   - After m_tready=1, names 10..13 emerge in order and name 14 is never output.
5. Simultaneous push/pop when full: FIFO full, m_tready=1 while pushing name 20 in the same cycle.
   - No overflow, fifo_count stays 4.
   - Name 20 emerges last.
6. Mid-stream reset: 3 entries queued, pulse reset=0 for 1 cycle.
   - m_tvalid=0 and fifo_count=0 immediately.
   - The next push is output with counter restarted, so tlast fires after K more words.
